image_scheduler: RTL and testbench
==================================

# image_scheduler

Sequences the screensaver's image generators. Selects one of `NUM_IMAGES` generator outputs and drives its pixels to the VGA output stage. Holds each image for a fixed number of frames, or until the user requests the next one, then fades it out, switches images, and fades the new one in. It also supplies the per-image `frame` count that the generators use for animation. It sits between the bank of image instances and the VGA output register.

## Interface
- `NUM_IMAGES`, 2: number of image generators; must be ≥ 2.
- `DWELL_FRAMES`, 600: frames each image is shown at full brightness; must be ≥ 1.
- `STEP_FRAMES`, 2: frames per brightness step during a fade; must be ≥ 1.

Ports:
- `clk` in 1: pixel clock.
- `rst` in 1: reset, asynchronous assert, active-low (0 = reset).
- `frame_start` in 1: one-cycle pulse once per frame, during blanking.
- `next_req` in 1: one-cycle pulse requesting the next image (debounced button).
- `img_r`, `img_g`, `img_b` in 4·NUM_IMAGES each: packed generator outputs; image k occupies bits [4k+3:4k].
- `r`, `g`, `b` out 4 each: scaled pixel of the selected image, registered.
- `frame` out 32: frames since the current image was selected; fan out to all generators.
- `sel` out $clog2(NUM_IMAGES): index of the current image.
- `fading` out 1: high in FADE_OUT and FADE_IN.

## Operation
- Reset values: state SHOW, `sel`=0, level=16, `frame`=0, `r`/`g`/`b`=0, dwell=0, step=0, pending=0, `fading`=0.
- level is a 5-bit brightness, 0..16. Pixel scaling: `r` = (img_r[sel] × level) >> 4, full-precision 4×5-bit product. level 16 passes the pixel through exactly; level 0 gives black. Same rule for g and b.
- `frame`: +1 on every `frame_start`, wraps modulo 2^32. Cleared to 0 on the cycle `sel` changes; the clear takes priority over the increment.
- pending request flag:
  - Set by `next_req` in SHOW.
  - Cleared on entry to FADE_OUT.
  - `next_req` during FADE_OUT or FADE_IN is dropped.
- State machine. All transitions and all level/`sel` updates occur only on `frame_start` cycles.
  - SHOW:
    - On `frame_start`, if (dwell == DWELL_FRAMES−1) or pending or `next_req`: go to FADE_OUT with step=0 and pending=0.
    - Otherwise dwell+1.
    - A `next_req` in the same cycle as `frame_start` counts.
  - FADE_OUT:
    - On `frame_start`, if step == STEP_FRAMES−1: step=0 and level−1.
    - If that makes level 0: `sel` = (sel == NUM_IMAGES−1) ? 0 : sel+1, `frame`=0, go to FADE_IN.
    - Otherwise step+1.
  - FADE_IN:
    - On `frame_start`, if step == STEP_FRAMES−1: step=0 and level+1.
    - If that makes level 16: go to SHOW with dwell=0.
    - Otherwise step+1.
- A full fade is 16 steps out and 16 steps in, i.e. 32·STEP_FRAMES frames.
- Reset asserted mid-operation returns every register to its reset value immediately; no partial fade resumes.

## Timing
- Pixel path latency is 1 cycle: `r`/`g`/`b` at cycle t+1 = f(img_*[sel] at t, level at t). The generators are already registered, so downstream blanking alignment stays at one extra stage.
- Updates to `sel`, level, `frame`, and `fading` are registered on the `frame_start` edge and visible the next cycle, i.e. during blanking, so there is no mid-line brightness change.
- `sel` and `frame` change in the same cycle, so a generator never sees a stale count for a new image.
- `fading` is asserted the cycle after the SHOW→FADE_OUT `frame_start`. It is deasserted the cycle after the FADE_IN→SHOW `frame_start`.
- No combinational path from any input to any output.

## Test plan
- **Reset.** Hold `rst`=0, drive img_r = all 4'hF. Required: `r`=0, `sel`=0, `frame`=0, `fading`=0. Release reset. Required: `r`=4'hF one cycle later (level 16).
- **Automatic cycle.** NUM_IMAGES=3, DWELL_FRAMES=4, STEP_FRAMES=1, pulse `frame_start` every 20 cycles.
  - Required: 4th pulse enters FADE_OUT.
  - After 16 more pulses: `sel`=1, `frame`=0.
  - After 16 more: SHOW.
  - After 3 full cycles: `sel` wraps to 0.
- **Scaling.** img_r=4'hF, img_g=4'h8, img_b=4'h1 at level 8. Required: `r`=7, `g`=4, `b`=0. At level 1: `r`=0. Check every level against (pix×level)>>4.
- **Early request.** DWELL_FRAMES=600. Pulse `next_req` mid-frame in SHOW. Required: FADE_OUT at the next `frame_start`. `next_req` coincident with `frame_start` also triggers on that cycle. `next_req` during a fade: no extra switch after the fade ends.
- **STEP_FRAMES=3.** Required: level changes on every 3rd `frame_start`, and the full fade takes 96 frames.
- **Reset mid-fade.** Assert `rst` at level 5 in FADE_OUT, `sel`=1. Required: immediately `sel`=0, level 16, `fading`=0, `frame`=0.

Source files
------------

// File: rtl/image_scheduler.sv
// rtl/image_scheduler.sv - selects, fades and sequences the screensaver image generators
module image_scheduler #(
    parameter int NUM_IMAGES   = 2,
    parameter int DWELL_FRAMES = 600,
    parameter int STEP_FRAMES  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          frame_start,
    input  logic                          next_req,
    input  logic [4*NUM_IMAGES-1:0]       img_r,
    input  logic [4*NUM_IMAGES-1:0]       img_g,
    input  logic [4*NUM_IMAGES-1:0]       img_b,
    output logic [3:0]                    r,
    output logic [3:0]                    g,
    output logic [3:0]                    b,
    output logic [31:0]                   frame,
    output logic [$clog2(NUM_IMAGES)-1:0] sel,
    output logic                          fading
);
    localparam int SW  = $clog2(NUM_IMAGES);
    localparam int DW  = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam int STW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

    typedef enum logic [1:0] {SHOW, FADE_OUT, FADE_IN} state_t;

    state_t         state, state_nxt;
    logic [SW-1:0]  sel_nxt;
    logic [4:0]     level, level_nxt;
    logic [31:0]    frame_nxt;
    logic [DW-1:0]  dwell, dwell_nxt;
    logic [STW-1:0] step, step_nxt;
    logic           pending, pending_nxt;
    logic [3:0]     pix_r, pix_g, pix_b;

    assign pix_r = img_r[{sel, 2'b00} +: 4];
    assign pix_g = img_g[{sel, 2'b00} +: 4];
    assign pix_b = img_b[{sel, 2'b00} +: 4];

    // Full-precision 4x5 product; level 16 is an exact pass-through.
    function automatic logic [3:0] scale(input logic [3:0] pix, input logic [4:0] lvl);
        return 4'(({4'd0, pix} * {3'd0, lvl}) >> 4);
    endfunction

    always_comb begin
        state_nxt   = state;
        sel_nxt     = sel;
        level_nxt   = level;
        frame_nxt   = frame_start ? frame + 32'd1 : frame;
        dwell_nxt   = dwell;
        step_nxt    = step;
        pending_nxt = pending;
        case (state)
            SHOW: begin
                if (next_req)
                    pending_nxt = 1'b1;
                if (frame_start) begin
                    if (dwell == DW'(DWELL_FRAMES - 1) || pending || next_req) begin
                        state_nxt   = FADE_OUT;
                        step_nxt    = '0;
                        pending_nxt = 1'b0;
                    end else begin
                        dwell_nxt = dwell + DW'(1);
                    end
                end
            end
            FADE_OUT: begin
                if (frame_start) begin
                    if (step == STW'(STEP_FRAMES - 1)) begin
                        step_nxt  = '0;
                        level_nxt = level - 5'd1;
                        // Switch image while black; frame clear overrides the increment.
                        if (level == 5'd1) begin
                            sel_nxt   = (sel == SW'(NUM_IMAGES - 1)) ? '0 : sel + SW'(1);
                            frame_nxt = '0;
                            state_nxt = FADE_IN;
                        end
                    end else begin
                        step_nxt = step + STW'(1);
                    end
                end
            end
            FADE_IN: begin
                if (frame_start) begin
                    if (step == STW'(STEP_FRAMES - 1)) begin
                        step_nxt  = '0;
                        level_nxt = level + 5'd1;
                        if (level == 5'd15) begin
                            state_nxt = SHOW;
                            dwell_nxt = '0;
                        end
                    end else begin
                        step_nxt = step + STW'(1);
                    end
                end
            end
            default: state_nxt = SHOW;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= SHOW;
            sel     <= '0;
            level   <= 5'd16;
            frame   <= '0;
            dwell   <= '0;
            step    <= '0;
            pending <= 1'b0;
            fading  <= 1'b0;
            r       <= '0;
            g       <= '0;
            b       <= '0;
        end else begin
            state   <= state_nxt;
            sel     <= sel_nxt;
            level   <= level_nxt;
            frame   <= frame_nxt;
            dwell   <= dwell_nxt;
            step    <= step_nxt;
            pending <= pending_nxt;
            fading  <= (state_nxt != SHOW);
            r       <= scale(pix_r, level);
            g       <= scale(pix_g, level);
            b       <= scale(pix_b, level);
        end
    end
endmodule

// File: tb/tb_image_scheduler.sv
// tb/tb_image_scheduler.sv - directed self-checking bench for image_scheduler
module tb_image_scheduler;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        fs_a, nr_a;
    logic [11:0] ir_a, ig_a, ib_a;
    logic [3:0]  r_a, g_a, b_a;
    logic [31:0] frame_a;
    logic [1:0]  sel_a;
    logic        fading_a;

    logic        fs_b, nr_b;
    logic [7:0]  ir_b, ig_b, ib_b;
    logic [3:0]  r_b, g_b, b_b;
    logic [31:0] frame_b;
    logic [0:0]  sel_b;
    logic        fading_b;

    image_scheduler #(.NUM_IMAGES(3), .DWELL_FRAMES(4), .STEP_FRAMES(1)) dut_a (
        .clk(clk), .rst(rst), .frame_start(fs_a), .next_req(nr_a),
        .img_r(ir_a), .img_g(ig_a), .img_b(ib_a),
        .r(r_a), .g(g_a), .b(b_a), .frame(frame_a), .sel(sel_a), .fading(fading_a)
    );

    image_scheduler #(.NUM_IMAGES(2), .DWELL_FRAMES(600), .STEP_FRAMES(3)) dut_b (
        .clk(clk), .rst(rst), .frame_start(fs_b), .next_req(nr_b),
        .img_r(ir_b), .img_g(ig_b), .img_b(ib_b),
        .r(r_b), .g(g_b), .b(b_b), .frame(frame_b), .sel(sel_b), .fading(fading_b)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a();
        fs_a = 1'b1;
        tick();
        fs_a = 1'b0;
    endtask

    task automatic pulse_b();
        fs_b = 1'b1;
        tick();
        fs_b = 1'b0;
    endtask

    typedef struct {
        int         lvl;
        logic [3:0] pr, pg, pb;
        logic [3:0] er, eg, eb;
    } scale_vec_t;

    scale_vec_t tbl[6];

    initial begin
        int row;
        int lvl;

        tbl[0] = '{16, 4'hF, 4'h8, 4'h1, 4'hF, 4'h8, 4'h1};
        tbl[1] = '{12, 4'hA, 4'h5, 4'h3, 4'h7, 4'h3, 4'h2};
        tbl[2] = '{8,  4'hF, 4'h8, 4'h1, 4'h7, 4'h4, 4'h0};
        tbl[3] = '{5,  4'h9, 4'hC, 4'h7, 4'h2, 4'h3, 4'h2};
        tbl[4] = '{1,  4'hF, 4'h8, 4'h1, 4'h0, 4'h0, 4'h0};
        tbl[5] = '{0,  4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0};

        rst  = 1'b0;
        fs_a = 1'b0; nr_a = 1'b0;
        fs_b = 1'b0; nr_b = 1'b0;
        ir_a = {3{4'hF}}; ig_a = {3{4'h8}}; ib_a = {3{4'h1}};
        ir_b = 8'hFF; ig_b = 8'hFF; ib_b = 8'hFF;
        tick(); tick();
        check("rst_r", r_a, 4'h0);
        check("rst_sel", sel_a, 0);
        check("rst_frame", frame_a, 0);
        check("rst_fading", fading_a, 0);
        rst = 1'b1;
        tick();
        check("rel_r_full", r_a, 4'hF);

        // Automatic cycle: dwell 4 frames, one frame per step, three images.
        for (int p = 1; p <= 92; p++) begin
            pulse_a();
            row = -1;
            for (int i = 0; i < 6; i++)
                if (56 - tbl[i].lvl == p) row = i;
            if (row >= 0) begin
                ir_a = {3{tbl[row].pr}}; ig_a = {3{tbl[row].pg}}; ib_a = {3{tbl[row].pb}};
            end else begin
                ir_a = {3{4'hF}}; ig_a = {3{4'h8}}; ib_a = {3{4'h1}};
            end
            tick();
            if (row >= 0) begin
                check($sformatf("tbl_r_l%0d", tbl[row].lvl), r_a, tbl[row].er);
                check($sformatf("tbl_g_l%0d", tbl[row].lvl), g_a, tbl[row].eg);
                check($sformatf("tbl_b_l%0d", tbl[row].lvl), b_a, tbl[row].eb);
            end
            if (p >= 4 && p <= 36) begin
                lvl = (p <= 20) ? 20 - p : p - 20;
                check($sformatf("sweep_r_l%0d", lvl), r_a, (15 * lvl) >> 4);
                check($sformatf("sweep_g_l%0d", lvl), g_a, (8 * lvl) >> 4);
                check($sformatf("sweep_b_l%0d", lvl), b_a, (1 * lvl) >> 4);
            end
            case (p)
                3:  begin check("a_p3_fading", fading_a, 0); check("a_p3_frame", frame_a, 3); end
                4:  begin check("a_p4_fading", fading_a, 1); check("a_p4_frame", frame_a, 4);
                          check("a_p4_sel", sel_a, 0); end
                19: check("a_p19_sel", sel_a, 0);
                20: begin check("a_p20_sel", sel_a, 1); check("a_p20_frame", frame_a, 0);
                          check("a_p20_fading", fading_a, 1); end
                35: check("a_p35_fading", fading_a, 1);
                36: begin check("a_p36_fading", fading_a, 0); check("a_p36_sel", sel_a, 1);
                          check("a_p36_frame", frame_a, 16); end
                56: begin check("a_p56_sel", sel_a, 2); check("a_p56_frame", frame_a, 0); end
                92: begin check("a_p92_sel_wrap", sel_a, 0); check("a_p92_frame", frame_a, 0); end
                default: ;
            endcase
        end

        // Early request, long dwell, three frames per step.
        pulse_b(); pulse_b();
        check("b_show_fading", fading_b, 0);
        nr_b = 1'b1; tick(); nr_b = 1'b0;
        tick(); tick();
        check("b_req_wait", fading_b, 0);
        pulse_b();
        check("b_req_fade", fading_b, 1);
        check("b_req_frame", frame_b, 3);
        for (int k = 1; k <= 96; k++) begin
            if (k == 10) begin
                nr_b = 1'b1; tick(); nr_b = 1'b0;
            end
            if (k == 60) nr_b = 1'b1;
            pulse_b();
            nr_b = 1'b0;
            tick();
            case (k)
                2:  check("b_k2_r", r_b, 4'hF);
                3:  check("b_k3_r", r_b, 4'hE);
                5:  check("b_k5_r", r_b, 4'hE);
                6:  check("b_k6_r", r_b, 4'hD);
                47: check("b_k47_sel", sel_b, 0);
                48: begin check("b_k48_sel", sel_b, 1); check("b_k48_frame", frame_b, 0);
                          check("b_k48_r", r_b, 4'h0); end
                95: check("b_k95_fading", fading_b, 1);
                96: begin check("b_k96_fading", fading_b, 0); check("b_k96_r", r_b, 4'hF);
                          check("b_k96_frame", frame_b, 48); end
                default: ;
            endcase
        end
        for (int k = 0; k < 5; k++) pulse_b();
        check("b_drop_fading", fading_b, 0);
        check("b_drop_sel", sel_b, 1);

        // Request coincident with frame_start triggers on that frame.
        fs_b = 1'b1; nr_b = 1'b1;
        tick();
        fs_b = 1'b0; nr_b = 1'b0;
        check("b_coinc_fading", fading_b, 1);
        for (int k = 0; k < 33; k++) pulse_b();
        tick();
        check("b_l5_r", r_b, 4'h4);
        check("b_l5_sel", sel_b, 1);

        // Reset mid-fade takes effect without waiting for a clock edge.
        rst = 1'b0;
        #1;
        check("mid_rst_sel", sel_b, 0);
        check("mid_rst_fading", fading_b, 0);
        check("mid_rst_frame", frame_b, 0);
        check("mid_rst_r", r_b, 4'h0);
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_r", r_b, 4'hF);
        pulse_b();
        check("post_rst_fading", fading_b, 0);
        check("post_rst_frame", frame_b, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
